// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR coefficient path.
// Imported by the loader and by anything that inspects its debug state.
package fir_pkg;

   localparam int TAPS_DEFAULT = 102;
   localparam int CW_DEFAULT   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      PEND  = 2'd3
   } loader_state_t;

   typedef enum logic [1:0] {
      NONE   = 2'b00,
      SHORT  = 2'b01,
      LONG   = 2'b10,
      ORPHAN = 2'b11
   } loader_err_t;

   typedef logic signed [CW_DEFAULT-1:0] coef_t;

endpackage

// File: rtl/fir_coef_loader.sv
// Framed coefficient loader: fills a shadow bank from a valid/ready stream and
// copies it atomically into the active bank when the filter grants a commit.
module fir_coef_loader
   import fir_pkg::*;
#(
   parameter int TAPS      = TAPS_DEFAULT,
   parameter int CW        = CW_DEFAULT,
   parameter bit SYMMETRIC = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic signed [CW-1:0] s_data,
   input  logic                 s_sof,
   input  logic                 s_last,
   input  logic                 commit_en,
   output logic [TAPS*CW-1:0]   coef_flat,
   output logic                 swap_pulse,
   output logic                 busy,
   output logic [1:0]           err,
   output loader_state_t        dbg_state
);

   // Handshake: a beat transfers on any rising edge where s_valid && s_ready.
   // s_ready never depends on s_valid; it drops only in PEND and during reset.
   localparam int N  = SYMMETRIC ? TAPS / 2 : TAPS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [AW-1:0] TOP_TAP  = AW'(TAPS - 1);

   loader_state_t          state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   loader_err_t            err_q, err_d;
   logic                   rdy_q;
   logic                   swap_q;
   logic signed [CW-1:0]   shadow_q [TAPS];
   logic signed [CW-1:0]   active_q [TAPS];

   logic                   accept;
   logic                   wr_en;
   logic [IW-1:0]          wr_idx;
   logic [AW-1:0]          wr_lo;
   logic [AW-1:0]          wr_hi;
   logic                   commit;

   assign s_ready    = rdy_q && (state_q != PEND);
   assign accept     = s_valid && s_ready;
   assign busy       = (state_q != IDLE);
   assign err        = err_q;
   assign swap_pulse = swap_q;
   assign dbg_state  = state_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      wr_idx  = '0;
      commit  = 1'b0;
      unique case (state_q)
         IDLE, DRAIN: begin
            if (accept) begin
               if (s_sof) begin
                  wr_en   = 1'b1;
                  idx_d   = IW'(1);
                  err_d   = NONE;
                  state_d = (N == 1 && s_last) ? PEND : LOAD;
               end else if (state_q == IDLE) begin
                  err_d = ORPHAN;
               end else if (s_last) begin
                  state_d = IDLE;
               end
            end
         end
         LOAD: begin
            if (accept) begin
               wr_en = 1'b1;
               if (s_sof) begin
                  idx_d   = IW'(1);
                  err_d   = NONE;
                  state_d = (N == 1 && s_last) ? PEND : LOAD;
               end else begin
                  wr_idx = idx_q;
                  if (idx_q == LAST_IDX) begin
                     if (s_last) begin
                        state_d = PEND;
                     end else begin
                        err_d   = LONG;
                        state_d = DRAIN;
                     end
                  end else if (s_last) begin
                     err_d   = SHORT;
                     state_d = IDLE;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
         end
         PEND: begin
            if (commit_en) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         err_q   <= NONE;
         rdy_q   <= 1'b0;
         swap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         rdy_q   <= 1'b1;
         swap_q  <= commit;
      end
   end

   // In symmetric mode each beat also lands on its mirror tap.
   assign wr_lo = AW'(wr_idx);
   assign wr_hi = TOP_TAP - wr_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) shadow_q[i] <= '0;
      end else if (wr_en) begin
         shadow_q[wr_lo] <= s_data;
         if (SYMMETRIC) shadow_q[wr_hi] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) active_q[i] <= '0;
      end else if (commit) begin
         for (int i = 0; i < TAPS; i++) active_q[i] <= shadow_q[i];
      end
   end

   for (genvar g = 0; g < TAPS; g++) begin : g_flat
      assign coef_flat[g*CW +: CW] = active_q[g];
   end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: symmetric load, short/long frames,
// commit hold, orphan/restart and reset in PEND.
module tb_fir_coef_loader;
   import fir_pkg::*;

   localparam int TAPS = 102;
   localparam int CW   = 32;
   localparam int N    = TAPS / 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic signed [CW-1:0] s_data = '0;
   logic                 s_sof = 1'b0;
   logic                 s_last = 1'b0;
   logic                 commit_en = 1'b0;
   logic [TAPS*CW-1:0]   coef_flat;
   logic                 swap_pulse;
   logic                 busy;
   logic [1:0]           err;
   loader_state_t        dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   int swap_cnt = 0;
   logic [CW-1:0] exp_q[$];

   fir_coef_loader #(.TAPS(TAPS), .CW(CW), .SYMMETRIC(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sof(s_sof), .s_last(s_last), .commit_en(commit_en),
      .coef_flat(coef_flat), .swap_pulse(swap_pulse), .busy(busy),
      .err(err), .dbg_state(dbg_state)
   );

   // clock / reset infrastructure
   always #5 clk = ~clk;

   always @(posedge clk) if (rst_n && swap_pulse) swap_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] tap(input int i);
      return coef_flat[i*CW +: CW];
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one beat; called at posedge+1, returns at posedge+1 after acceptance.
   task automatic send_beat(input logic [CW-1:0] d, input logic sof, input logic last);
      int w;
      w = 0;
      while (!s_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check_eq("beat_ready", {63'd0, s_ready}, 64'd1);
      s_valid = 1'b1;
      s_data  = d;
      s_sof   = sof;
      s_last  = last;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int base);
      for (int i = 0; i < N; i++) send_beat(CW'(base + i), i == 0, i == N - 1);
   endtask

   // Expected symmetric bank for a frame whose beat i carries base+i.
   task automatic expect_bank(input int base);
      for (int i = 0; i < TAPS; i++)
         exp_q.push_back(CW'((i < N) ? base + i : base + (TAPS - 1 - i)));
   endtask

   task automatic compare_bank(input string tag);
      for (int i = 0; i < TAPS; i++) begin
         if (exp_q.size() == 0) begin
            check_eq({tag, "_q_empty"}, 64'd0, 64'd1);
            return;
         end
         check_eq(tag, {32'd0, tap(i)}, {32'd0, exp_q.pop_front()});
      end
   endtask

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_ready", {63'd0, s_ready}, 64'd0);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_err", {62'd0, err}, 64'd0);
      check_eq("rst_swap", {63'd0, swap_pulse}, 64'd0);
      check_eq("rst_coef", {32'd0, tap(0) | tap(TAPS-1)}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("ready_after_rst", {63'd0, s_ready}, 64'd1);

      // symmetric load of 1..51, commit_en held high
      commit_en = 1'b1;
      send_frame(1);
      check_eq("sym_pend_busy", {63'd0, busy}, 64'd1);
      check_eq("sym_pend_ready", {63'd0, s_ready}, 64'd0);
      check_eq("sym_pend_state", {62'd0, dbg_state}, {62'd0, PEND});
      check_eq("sym_no_early_swap", {63'd0, swap_pulse}, 64'd0);
      cycles(1);
      check_eq("sym_swap", {63'd0, swap_pulse}, 64'd1);
      check_eq("sym_tap0", {32'd0, tap(0)}, 64'd1);
      check_eq("sym_tap101", {32'd0, tap(101)}, 64'd1);
      check_eq("sym_tap50", {32'd0, tap(50)}, 64'd51);
      check_eq("sym_tap51", {32'd0, tap(51)}, 64'd51);
      expect_bank(1);
      compare_bank("sym_bank");
      cycles(1);
      check_eq("sym_swap_once", {63'd0, swap_pulse}, 64'd0);
      check_eq("sym_idle", {63'd0, busy}, 64'd0);
      check_eq("sym_swap_cnt", 64'(swap_cnt), 64'd1);

      // short frame: last on beat 20
      for (int i = 0; i <= 20; i++) send_beat(CW'(100 + i), i == 0, i == 20);
      check_eq("short_err", {62'd0, err}, 64'd1);
      check_eq("short_idle", {63'd0, busy}, 64'd0);
      cycles(3);
      check_eq("short_tap0", {32'd0, tap(0)}, 64'd1);
      check_eq("short_tap20", {32'd0, tap(20)}, 64'd21);
      check_eq("short_tap81", {32'd0, tap(81)}, 64'd21);
      check_eq("short_no_swap", 64'(swap_cnt), 64'd1);

      // long frame: 60 beats, last on beat 59
      for (int i = 0; i < 60; i++) begin
         send_beat(CW'(200 + i), i == 0, i == 59);
         if (i == 0) check_eq("long_err_cleared", {62'd0, err}, 64'd0);
         if (i == 50) begin
            check_eq("long_err", {62'd0, err}, 64'd2);
            check_eq("long_drain_busy", {63'd0, busy}, 64'd1);
         end
      end
      check_eq("long_idle", {63'd0, busy}, 64'd0);
      check_eq("long_err_hold", {62'd0, err}, 64'd2);
      cycles(3);
      check_eq("long_tap0", {32'd0, tap(0)}, 64'd1);
      check_eq("long_tap50", {32'd0, tap(50)}, 64'd51);
      check_eq("long_no_swap", 64'(swap_cnt), 64'd1);

      // commit hold for 10 cycles
      commit_en = 1'b0;
      send_frame(300);
      for (int c = 0; c < 10; c++) begin
         check_eq("hold_ready", {63'd0, s_ready}, 64'd0);
         check_eq("hold_busy", {63'd0, busy}, 64'd1);
         check_eq("hold_swap", {63'd0, swap_pulse}, 64'd0);
         cycles(1);
      end
      check_eq("hold_tap0_old", {32'd0, tap(0)}, 64'd1);
      commit_en = 1'b1;
      cycles(1);
      check_eq("hold_swap_now", {63'd0, swap_pulse}, 64'd1);
      check_eq("hold_tap0", {32'd0, tap(0)}, 64'd300);
      check_eq("hold_tap101", {32'd0, tap(101)}, 64'd300);
      check_eq("hold_tap50", {32'd0, tap(50)}, 64'd350);
      check_eq("hold_tap51", {32'd0, tap(51)}, 64'd350);
      cycles(1);

      // orphan beat, then mid-frame restart at index 30
      send_beat(CW'(999), 1'b0, 1'b0);
      check_eq("orphan_err", {62'd0, err}, 64'd3);
      check_eq("orphan_idle", {63'd0, busy}, 64'd0);
      for (int i = 0; i < 30; i++) send_beat(CW'(400 + i), i == 0, 1'b0);
      check_eq("restart_err_pre", {62'd0, err}, 64'd0);
      send_frame(500);
      check_eq("restart_err", {62'd0, err}, 64'd0);
      cycles(1);
      check_eq("restart_swap", {63'd0, swap_pulse}, 64'd1);
      check_eq("restart_tap30", {32'd0, tap(30)}, 64'd530);
      check_eq("restart_tap71", {32'd0, tap(71)}, 64'd530);
      expect_bank(500);
      compare_bank("restart_bank");
      cycles(1);
      check_eq("swap_total", 64'(swap_cnt), 64'd3);

      // reset while in PEND
      commit_en = 1'b0;
      send_frame(600);
      check_eq("pre_rst_pend", {62'd0, dbg_state}, {62'd0, PEND});
      rst_n = 1'b0;
      #1;
      check_eq("pend_rst_tap0", {32'd0, tap(0)}, 64'd0);
      check_eq("pend_rst_tap50", {32'd0, tap(50)}, 64'd0);
      check_eq("pend_rst_busy", {63'd0, busy}, 64'd0);
      check_eq("pend_rst_ready", {63'd0, s_ready}, 64'd0);
      check_eq("pend_rst_err", {62'd0, err}, 64'd0);
      cycles(2);
      check_eq("pend_rst_ready_held", {63'd0, s_ready}, 64'd0);
      check_eq("pend_rst_swap", {63'd0, swap_pulse}, 64'd0);
      rst_n = 1'b1;
      cycles(1);
      check_eq("post_rst_ready", {63'd0, s_ready}, 64'd1);
      check_eq("post_rst_tap101", {32'd0, tap(101)}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
